rom_download_writer: RTL and testbench
======================================

// Module: rom_download_writer
// PURPOSE
// - Write side of the ROM path: packs the HPS ioctl byte stream into 32-bit words and
//   issues SDRAM write requests; the game's ROM fetchers later read these words back.
// - Sits between hps_io (ioctl_*) and the sdram controller port, muxed in while ioctl_download=1.
// PARAMETERS
// - FIFO_DEPTH      4   word entries buffered between packer and SDRAM requester (power of 2, >=2)
// - IOCTL_ADDR_W    25  ioctl byte-address width
// - SDRAM_ADDR_W    23  SDRAM word-address width (= IOCTL_ADDR_W-2)
// PORTS
// - clk             in   1   system clock (48 MHz clk_sys)
// - reset           in   1   synchronous, active-high
// - ioctl_addr      in   25  byte address of ioctl_data
// - ioctl_data      in   8   download byte
// - ioctl_wr        in   1   one-cycle byte strobe
// - ioctl_download  in   1   level, high for the whole download
// - ioctl_wait      out  1   backpressure to hps_io
// - sdram_addr      out  23  word address
// - sdram_din       out  32  write data, byte n = ioctl byte (addr[1:0]==n)
// - sdram_we        out  1   1 whenever sdram_req=1
// - sdram_req       out  1   request, held until ack
// - sdram_ack       in   1   one-cycle: request accepted
// - sdram_ready     in   1   controller initialised
// - busy            out  1   packer, FIFO or requester non-empty
// - done            out  1   one-cycle pulse: last word of a download acked
// - overflow        out  1   sticky: a word was dropped on a full FIFO
// BEHAVIOUR
// - Reset: all outputs 0; pack lanes, lane mask, FIFO and requester cleared; an in-flight
//   request is abandoned (controller shares reset). Overflow cleared only by reset.
// - Packer: current word address W and 4-bit lane mask M. On ioctl_wr with
//   ioctl_addr[24:2]==W (or M==0): write lane ioctl_addr[1:0], set M bit, load W.
// - M==4'b1111 after a write -> push {W, lanes} next cycle, M<=0.
// - ioctl_wr with ioctl_addr[24:2]!=W and M!=0: push partial word (unwritten lanes = 8'h00)
//   this cycle; new byte starts a fresh word (M = its lane only). Max one push per cycle.
// - ioctl_download falling edge with M!=0: flush partial word the next cycle. ioctl_wr in
//   the same cycle as the fall is accepted first, then flushed.
// - Push onto full FIFO: word dropped, overflow<=1; never blocks the packer.
// - ioctl_wait = (fifo_count >= FIFO_DEPTH-1) | (sdram_ready==0 & ioctl_download).
// - Requester FSM: IDLE -> REQ when FIFO non-empty & sdram_ready: register head into
//   sdram_addr/din, req=we=1. REQ: outputs stable; on sdram_ack pop FIFO; if FIFO still
//   non-empty go straight to next REQ (req stays high, new addr/din next cycle), else IDLE.
// - Latency: 4th-byte strobe at cycle t -> push t+1 -> sdram_req high t+2 (FIFO empty, ready).
// - ack in IDLE ignored. sdram_ready dropping while in REQ: hold request until ack.
// - done: pulses the cycle after the ack that empties FIFO with packer empty and
//   ioctl_download=0; busy = (M!=0) | fifo non-empty | state==REQ.
// - Address wrap: none; W is a plain copy of ioctl_addr[24:2].
// STRUCTURE
// - rom_download_pkg: IOCTL_ADDR_W, SDRAM_ADDR_W, word_t (32b), wr_entry_t {addr,data},
//   req_state_t {IDLE, REQ}.
// - Sub-module download_fifo: synchronous FWFT FIFO of wr_entry_t, count output,
//   simultaneous push+pop on full/empty legal (full: pop frees slot same cycle).
// - Top: packer, edge detect on ioctl_download, requester FSM, flags.
// TESTING
// - 8 bytes 00..07 at addr 0..7, ack 1 cycle after req -> writes (0,0x03020100), (1,0x07060504); done once.
// - 6 bytes at 0x100..0x105 then download falls -> (0x40,0x03020100), (0x41,0x00000504).
// - Bytes at 0x10,0x11 then 0x20 -> (0x4,0x00001100-pattern zero-filled) pushed before 0x20's word.
// - Hold sdram_ack low 50 cycles while streaming -> ioctl_wait rises at count 3; no overflow; order kept.
// - Ignore ioctl_wait, 6 words with no ack -> overflow=1, first 4 words written intact.
// - Reset asserted in REQ with partial word -> next cycle req=0, busy=0, no write emitted.

Source files
------------

// File: rtl/rom_download_pkg.sv
// Shared types for the ROM download write path: entry/word types, requester states
// and a lane-mask helper.
package rom_download_pkg;

    localparam int IOCTL_ADDR_W       = 25;
    localparam int SDRAM_ADDR_W       = IOCTL_ADDR_W - 2;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [SDRAM_ADDR_W-1:0] addr;
        word_t                   data;
    } wr_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } req_state_t;

    function automatic logic [3:0] lane_bit(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/download_fifo.sv
// First-word-fall-through FIFO of write entries; exposes the head and the entry behind it
// so the requester can chain back-to-back requests. A pop frees a slot for a same-cycle push.
module download_fifo
    import rom_download_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  wr_entry_t                data_i,
    input  logic                     pop_i,
    output wr_entry_t                head_o,
    output wr_entry_t                next_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    wr_entry_t       mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [AW:0]     cnt_q;
    logic            push_ok;
    logic            pop_ok;

    assign empty_o = (cnt_q == {(AW+1){1'b0}});
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);
    assign head_o  = mem_q[rd_q];
    assign next_o  = mem_q[rd_q + PTR_ONE];
    assign count_o = cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + PTR_ONE;
            end
            if (pop_ok) begin
                rd_q <= rd_q + PTR_ONE;
            end
            cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/rom_download_writer.sv
// Packs the hps_io byte stream into 32-bit words, queues them and issues SDRAM write
// requests, with download-end flush, backpressure and overflow/done flags.
module rom_download_writer
    import rom_download_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [IOCTL_ADDR_W-1:0]  ioctl_addr,
    input  logic [7:0]               ioctl_data,
    input  logic                     ioctl_wr,
    input  logic                     ioctl_download,
    output logic                     ioctl_wait,
    output logic [SDRAM_ADDR_W-1:0]  sdram_addr,
    output logic [31:0]              sdram_din,
    output logic                     sdram_we,
    output logic                     sdram_req,
    input  logic                     sdram_ack,
    input  logic                     sdram_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [SDRAM_ADDR_W-1:0] w_q, w_d;
    logic [3:0]              m_q, m_d;
    word_t                   lanes_q, lanes_d;
    logic                    flush_q, flush_d;
    wr_entry_t               flush_entry_q, flush_entry_d;
    logic                    dl_q;
    req_state_t              state_q, state_d;
    logic [SDRAM_ADDR_W-1:0] addr_q, addr_d;
    word_t                   din_q, din_d;
    logic                    done_q, done_d;
    logic                    ovf_q, ovf_d;

    logic                    fifo_push, fifo_pop, fifo_full, fifo_empty;
    wr_entry_t               push_entry, fifo_head, fifo_next;
    logic [CNT_W-1:0]        fifo_count;
    logic [SDRAM_ADDR_W-1:0] byte_word;
    logic [1:0]              lane;
    logic                    dl_fall;

    assign byte_word = ioctl_addr[IOCTL_ADDR_W-1:2];
    assign lane      = ioctl_addr[1:0];
    assign dl_fall   = dl_q & ~ioctl_download;

    download_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .data_i  (push_entry),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .next_o  (fifo_next),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A full word or an address change pushes immediately; the download-end flush is deferred one cycle.
    always_comb begin
        w_d           = w_q;
        m_d           = m_q;
        lanes_d       = lanes_q;
        flush_d       = 1'b0;
        flush_entry_d = flush_entry_q;
        fifo_push     = flush_q;
        push_entry    = flush_entry_q;
        if (ioctl_wr) begin
            if ((m_q != 4'b0000) && (byte_word != w_q)) begin
                fifo_push  = 1'b1;
                push_entry = '{addr: w_q, data: lanes_q};
                m_d        = 4'b0000;
                lanes_d    = '0;
            end else begin
                m_d = m_q;
            end
            w_d                        = byte_word;
            lanes_d[{lane, 3'b000} +: 8] = ioctl_data;
            m_d                        = m_d | lane_bit(lane);
            if (m_d == 4'b1111) begin
                fifo_push  = 1'b1;
                push_entry = '{addr: w_d, data: lanes_d};
                m_d        = 4'b0000;
                lanes_d    = '0;
            end else begin
                lanes_d = lanes_d;
            end
        end else begin
            w_d = w_q;
        end
        if (dl_fall && (m_d != 4'b0000)) begin
            flush_d       = 1'b1;
            flush_entry_d = '{addr: w_d, data: lanes_d};
            m_d           = 4'b0000;
            lanes_d       = '0;
        end else begin
            flush_d = 1'b0;
        end
    end

    // Requester: the head stays in the FIFO until acked, so the count includes the in-flight word.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        din_d    = din_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && sdram_ready) begin
                    state_d = REQ;
                    addr_d  = fifo_head.addr;
                    din_d   = fifo_head.data;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (sdram_ack) begin
                    fifo_pop = 1'b1;
                    if (fifo_count > CNT_W'(1)) begin
                        addr_d = fifo_next.addr;
                        din_d  = fifo_next.data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign done_d = (state_q == REQ) & sdram_ack & (fifo_count == CNT_W'(1)) & ~fifo_push
                  & (m_d == 4'b0000) & ~flush_d & ~ioctl_download;
    assign ovf_d  = ovf_q | (fifo_push & fifo_full & ~fifo_pop);

    // State registers for packer, edge detect, requester and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_q           <= '0;
            m_q           <= 4'b0000;
            lanes_q       <= '0;
            flush_q       <= 1'b0;
            flush_entry_q <= '0;
            dl_q          <= 1'b0;
            state_q       <= IDLE;
            addr_q        <= '0;
            din_q         <= '0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            w_q           <= w_d;
            m_q           <= m_d;
            lanes_q       <= lanes_d;
            flush_q       <= flush_d;
            flush_entry_q <= flush_entry_d;
            dl_q          <= ioctl_download;
            state_q       <= state_d;
            addr_q        <= addr_d;
            din_q         <= din_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
        end
    end

    assign sdram_req  = (state_q == REQ);
    assign sdram_we   = (state_q == REQ);
    assign sdram_addr = addr_q;
    assign sdram_din  = din_q;
    assign done       = done_q;
    assign overflow   = ovf_q;
    assign busy       = (m_q != 4'b0000) | flush_q | ~fifo_empty | (state_q == REQ);
    assign ioctl_wait = (fifo_count >= CNT_W'(FIFO_DEPTH - 1)) | (~sdram_ready & ioctl_download);

endmodule

// File: tb/tb_rom_download_writer.sv
// Self-checking bench: byte stream model predicts the ordered list of SDRAM word writes,
// a compare process scores every accepted request, directed cases pin literal results.
module tb_rom_download_writer;
    import rom_download_pkg::*;

    logic        clk = 1'b0;
    logic        reset, ioctl_wr, ioctl_download, ioctl_wait;
    logic        sdram_we, sdram_req, sdram_ack, sdram_ready, busy, done, overflow;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic [22:0] sdram_addr;
    logic [31:0] sdram_din;

    always #5 clk = ~clk;

    rom_download_writer dut (
        .clk(clk), .reset(reset), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .ioctl_download(ioctl_download), .ioctl_wait(ioctl_wait),
        .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_we(sdram_we),
        .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_ready(sdram_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    int checks = 0;
    int failures = 0;
    logic [22:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [22:0] got_a[$];
    logic [31:0] got_d[$];
    int  done_cnt = 0;
    int  req_cycles = 0;
    bit  ack_en = 1'b1;
    bit  ready_rand = 1'b0;
    bit  ovf_ok = 1'b0;
    int  ack_rnd = 0;

    // Model: open word being assembled from the byte stream.
    logic [22:0] m_word = '0;
    logic [31:0] m_data = '0;
    logic [3:0]  m_mask = '0;
    int          emit_cap = 1000000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic emit(input logic [22:0] w, input logic [31:0] d);
        if (emit_cap > 0) begin
            exp_a.push_back(w);
            exp_d.push_back(d);
            emit_cap--;
        end
    endtask

    task automatic model_byte(input logic [24:0] a, input logic [7:0] d);
        if (m_mask != 4'h0 && a[24:2] != m_word) begin
            emit(m_word, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
        m_word = a[24:2];
        m_data[a[1:0]*8 +: 8] = d;
        m_mask[a[1:0]] = 1'b1;
        if (m_mask == 4'hF) begin
            emit(m_word, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
    endtask

    task automatic model_fall();
        if (m_mask != 4'h0) begin
            emit(m_word, m_data);
            m_mask = 4'h0;
            m_data = '0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_no_wait();
        int n = 0;
        while (ioctl_wait && n < 1000) begin
            tick();
            n++;
        end
        chk("wait_timeout", n >= 1000, 1'b0);
    endtask

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d, input bit obey);
        if (obey) wait_no_wait();
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        model_byte(a, d);
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic end_dl();
        ioctl_download = 1'b0;
        model_fall();
        tick();
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((busy || exp_a.size() != 0) && n < 3000) begin
            tick();
            n++;
        end
        chk({nm, "_idle_timeout"}, n >= 3000, 1'b0);
        repeat (3) tick();
        chk({nm, "_busy"}, busy, 1'b0);
    endtask

    task automatic clear_logs();
        got_a.delete();
        got_d.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_a.delete();
        exp_d.delete();
        m_mask = 4'h0;
        m_data = '0;
        clear_logs();
    endtask

    // SDRAM controller model: random-latency one-cycle ack.
    initial begin
        sdram_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            sdram_ack = ack_en && sdram_req && sdram_ready && !reset && ($urandom_range(0, ack_rnd) == 0);
        end
    end

    // Controller ready, optionally dropping at random.
    initial begin
        sdram_ready = 1'b1;
        forever begin
            @(posedge clk);
            #3;
            if (ready_rand) sdram_ready = sdram_ready ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 3) == 0);
            else sdram_ready = 1'b1;
        end
    end

    // Compare process: scores every accepted request against the model queue.
    initial begin
        logic        prev_req = 1'b0, prev_ack = 1'b0;
        logic [22:0] prev_a = '0;
        logic [31:0] prev_d = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_req = 1'b0;
                prev_ack = 1'b0;
            end else begin
                chk("we_eq_req", sdram_we, sdram_req);
                if (!sdram_ready && ioctl_download) chk("wait_notready", ioctl_wait, 1'b1);
                if (sdram_req && prev_req && !prev_ack) begin
                    chk("req_addr_stable", sdram_addr, prev_a);
                    chk("req_din_stable", sdram_din, prev_d);
                end
                if (sdram_req && sdram_ack) begin
                    chk("write_expected", exp_a.size() != 0, 1'b1);
                    if (exp_a.size() != 0) begin
                        chk("write_addr", sdram_addr, exp_a.pop_front());
                        chk("write_data", sdram_din, exp_d.pop_front());
                    end
                    got_a.push_back(sdram_addr);
                    got_d.push_back(sdram_din);
                end
                if (!ovf_ok) chk("no_overflow", overflow, 1'b0);
                if (done) done_cnt++;
                if (sdram_req) req_cycles++;
                prev_req = sdram_req;
                prev_ack = sdram_ack;
                prev_a   = sdram_addr;
                prev_d   = sdram_din;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] a;
        int          n;
        reset = 1'b1;
        ioctl_wr = 1'b0;
        ioctl_download = 1'b0;
        ioctl_addr = '0;
        ioctl_data = '0;
        repeat (3) tick();
        chk("rst_req", sdram_req, 1'b0);
        chk("rst_we", sdram_we, 1'b0);
        chk("rst_addr", sdram_addr, 23'h0);
        chk("rst_din", sdram_din, 32'h0);
        chk("rst_wait", ioctl_wait, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ovf", overflow, 1'b0);
        reset = 1'b0;
        tick();

        // Two full words, immediate ack, plus latency of the first request.
        ioctl_download = 1'b1;
        for (int i = 0; i < 4; i++) put_byte(25'(i), 8'(i), 1'b1);
        chk("lat_push_cycle", sdram_req, 1'b0);
        tick();
        chk("lat_req_cycle", sdram_req, 1'b1);
        for (int i = 4; i < 8; i++) put_byte(25'(i), 8'(i), 1'b1);
        end_dl();
        wait_idle("t1");
        chk("t1_nwr", got_a.size(), 2);
        chk("t1_a0", got_a[0], 23'h0);
        chk("t1_d0", got_d[0], 32'h03020100);
        chk("t1_a1", got_a[1], 23'h1);
        chk("t1_d1", got_d[1], 32'h07060504);
        chk("t1_done", done_cnt, 1);
        clear_logs();

        // Partial last word flushed on download end.
        ack_rnd = 2;
        ioctl_download = 1'b1;
        for (int i = 0; i < 6; i++) put_byte(25'h100 + 25'(i), 8'(i), 1'b1);
        end_dl();
        wait_idle("t2");
        chk("t2_a0", got_a[0], 23'h40);
        chk("t2_d0", got_d[0], 32'h03020100);
        chk("t2_a1", got_a[1], 23'h41);
        chk("t2_d1", got_d[1], 32'h00000504);
        chk("t2_done", done_cnt, 1);
        clear_logs();

        // Address change pushes the zero-filled partial word first.
        ioctl_download = 1'b1;
        put_byte(25'h10, 8'hAA, 1'b1);
        put_byte(25'h11, 8'hBB, 1'b1);
        put_byte(25'h20, 8'hCC, 1'b1);
        end_dl();
        wait_idle("t3");
        chk("t3_a0", got_a[0], 23'h4);
        chk("t3_d0", got_d[0], 32'h0000BBAA);
        chk("t3_a1", got_a[1], 23'h8);
        chk("t3_d1", got_d[1], 32'h000000CC);
        chk("t3_done", done_cnt, 1);
        clear_logs();

        // Stalled acks: backpressure at three queued words, order kept.
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        for (int i = 0; i < 11; i++) put_byte(25'h300 + 25'(i), 8'h40 + 8'(i), 1'b0);
        chk("t4_wait_at2", ioctl_wait, 1'b0);
        put_byte(25'h30B, 8'h4B, 1'b0);
        chk("t4_wait_at3", ioctl_wait, 1'b1);
        fork
            begin
                repeat (50) @(posedge clk);
                ack_en = 1'b1;
            end
            begin
                for (int i = 12; i < 24; i++) put_byte(25'h300 + 25'(i), 8'h40 + 8'(i), 1'b1);
            end
        join
        end_dl();
        wait_idle("t4");
        chk("t4_nwr", got_a.size(), 6);
        chk("t4_ovf", overflow, 1'b0);
        chk("t4_done", done_cnt, 1);
        clear_logs();

        // Randomised downloads with random ready and ack latency.
        ready_rand = 1'b1;
        ack_rnd = 3;
        for (int s = 0; s < 6; s++) begin
            ioctl_download = 1'b1;
            n = $urandom_range(1, 40);
            a = 25'($urandom_range(0, 32'h1FF_FFFF));
            for (int k = 0; k < n; k++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (k == n - 1 && (s % 2) == 1) begin
                    wait_no_wait();
                    ioctl_download = 1'b0;
                    put_byte(a, 8'($urandom), 1'b0);
                    model_fall();
                end else begin
                    put_byte(a, 8'($urandom), 1'b1);
                end
                case ($urandom_range(0, 9))
                    0, 1:    a = {a[24:2], 2'($urandom)};
                    2:       a = 25'($urandom_range(0, 32'h1FF_FFFF));
                    default: a = a + 25'd1;
                endcase
            end
            if (ioctl_download) end_dl();
            wait_idle("rnd");
            chk("rnd_done", done_cnt, 1);
            clear_logs();
        end
        ready_rand = 1'b0;

        // Overflow: six words with no ack, first four kept intact.
        do_reset();
        ack_en = 1'b0;
        ovf_ok = 1'b1;
        emit_cap = 4;
        ioctl_download = 1'b1;
        for (int i = 0; i < 24; i++) put_byte(25'h400 + 25'(i), 8'(i) ^ 8'h5A, 1'b0);
        chk("t6_ovf_set", overflow, 1'b1);
        end_dl();
        ack_en = 1'b1;
        wait_idle("t6");
        chk("t6_ovf_sticky", overflow, 1'b1);
        chk("t6_nwr", got_a.size(), 4);
        chk("t6_a0", got_a[0], 23'h100);
        chk("t6_d0", got_d[0], 32'h59585B5A);
        chk("t6_a3", got_a[3], 23'h103);
        chk("t6_d3", got_d[3], 32'h55545756);
        chk("t6_done", done_cnt, 1);
        do_reset();
        chk("t6_ovf_cleared", overflow, 1'b0);
        ovf_ok = 1'b0;
        emit_cap = 1000000;

        // Reset while a request is in flight and a partial word is open.
        ack_en = 1'b0;
        ioctl_download = 1'b1;
        for (int i = 0; i < 5; i++) put_byte(25'h500 + 25'(i), 8'(i), 1'b0);
        n = 0;
        while (!sdram_req && n < 30) begin
            tick();
            n++;
        end
        chk("t7_req_timeout", n >= 30, 1'b0);
        reset = 1'b1;
        tick();
        chk("t7_req_after_rst", sdram_req, 1'b0);
        chk("t7_busy_after_rst", busy, 1'b0);
        reset = 1'b0;
        exp_a.delete();
        exp_d.delete();
        m_mask = 4'h0;
        m_data = '0;
        clear_logs();
        req_cycles = 0;
        ioctl_download = 1'b0;
        ack_en = 1'b1;
        repeat (20) tick();
        chk("t7_no_req", req_cycles, 0);
        chk("t7_no_write", got_a.size(), 0);
        chk("t7_no_done", done_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
